// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for the EX stage: owns HI/LO, models multi-cycle latency
// with a down counter, and raises the ID-stage stall while the unit is occupied.
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        isMDU_ID,
  output logic        Busy,
  output logic        Stall_MDU,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = (MAX_CYC > 15) ? $clog2(MAX_CYC + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext, loadCnt;
  logic [63:0]      result;
  logic             resultWr, arithOp, accept, commit, mtWrite;
  logic [31:0]      pendHi_p1, pendLo_p1;
  logic             pendWr_p1;

  function automatic logic [63:0] mulSigned(input logic signed [31:0] a,
                                            input logic signed [31:0] b);
    logic signed [63:0] pa, pb, prod;
    pa   = {{32{a[31]}}, a};
    pb   = {{32{b[31]}}, b};
    prod = pa * pb;
    return prod;
  endfunction

  function automatic logic [63:0] mulUnsigned(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Magnitude division avoids the 0x80000000 / -1 overflow; result is {rem, quot}.
  function automatic logic [63:0] divSigned(input logic signed [31:0] a,
                                            input logic signed [31:0] b);
    logic [31:0] absA, absB, q, r, quot, rem;
    absA = a[31] ? -a : a;
    absB = b[31] ? -b : b;
    if (absB == 32'd0) return 64'd0;
    q    = absA / absB;
    r    = absA % absB;
    quot = (a[31] ^ b[31]) ? -q : q;
    rem  = a[31] ? -r : r;
    return {rem, quot};
  endfunction

  function automatic logic [63:0] divUnsigned(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  always_comb begin
    result   = '0;
    resultWr = 1'b0;
    arithOp  = 1'b0;
    loadCnt  = '0;
    case (MDUOp)
      4'd1: begin arithOp = 1'b1; result = mulSigned(A, B);   resultWr = 1'b1;       loadCnt = CNT_W'(MULT_CYC); end
      4'd2: begin arithOp = 1'b1; result = mulUnsigned(A, B); resultWr = 1'b1;       loadCnt = CNT_W'(MULT_CYC); end
      4'd3: begin arithOp = 1'b1; result = divSigned(A, B);   resultWr = (B != '0);  loadCnt = CNT_W'(DIV_CYC);  end
      4'd4: begin arithOp = 1'b1; result = divUnsigned(A, B); resultWr = (B != '0);  loadCnt = CNT_W'(DIV_CYC);  end
      default: ;
    endcase
  end

  assign accept    = Start && !Req && arithOp && (state == IDLE);
  assign Busy      = (Start && !Req && arithOp) || (state == BUSY);
  assign Stall_MDU = isMDU_ID && Busy;
  assign commit    = (state == BUSY) && (cnt == CNT_ONE);
  assign mtWrite   = !Req && (state == IDLE);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: if (accept) begin
        stateNext = BUSY;
        cntNext   = loadCnt;
      end
      BUSY: begin
        cntNext = cnt - CNT_ONE;
        if (cnt == CNT_ONE) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pendHi_p1 <= '0;
      pendLo_p1 <= '0;
      pendWr_p1 <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      // Stage p1: result captured at Start, held until the counter expires
      if (accept) begin
        {pendHi_p1, pendLo_p1} <= result;
        pendWr_p1              <= resultWr;
      end
      if (commit) begin
        if (pendWr_p1) begin
          HI <= pendHi_p1;
          LO <= pendLo_p1;
        end
      end else begin
        if (mtWrite && MDUOp == 4'd7) HI <= A;
        if (mtWrite && MDUOp == 4'd8) LO <= A;
      end
    end
  end

  always_comb begin
    Out = '0;
    case (MDUOp)
      4'd5:    Out = HI;
      4'd6:    Out = LO;
      default: Out = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and busy length are queued at
// issue time and checked by a monitor when Busy drops.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, Req, Start, isMDU_ID;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        Busy, Stall_MDU;
  logic [31:0] HI, LO, Out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .Req(Req), .Start(Start), .MDUOp(MDUOp),
    .A(A), .B(B), .isMDU_ID(isMDU_ID), .Busy(Busy), .Stall_MDU(Stall_MDU),
    .HI(HI), .LO(LO), .Out(Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] hi, input logic [31:0] lo, input int len);
    exp_t e;
    e.hi = hi; e.lo = lo; e.len = len;
    sbq.push_back(e);
  endtask

  // Issue one arithmetic op at posedge+1; checks Busy (and optionally the stall) over its window.
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int len,
                       input logic idProbe, input logic poke);
    pushExp(eh, el, len);
    Start = 1'b1; MDUOp = op; A = a; B = b; isMDU_ID = idProbe;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("busy_window", 32'(Busy), 32'd1);
      if (idProbe) chk("stall_busy", 32'(Stall_MDU), 32'd1);
      step();
      Start = 1'b0;
      MDUOp = (poke && k == 0) ? 4'd7 : 4'd0;
      if (poke && k == 0) A = 32'hCAFEF00D;
    end
    @(negedge clk);
    chk("busy_done", 32'(Busy), 32'd0);
    if (idProbe) chk("stall_released", 32'(Stall_MDU), 32'd0);
    step();
    isMDU_ID = 1'b0;
  endtask

  initial begin : monitor
    int   run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (Busy === 1'b1) run++;
      else if (run > 0) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL commit_unexpected: busy run %0d with empty scoreboard", run);
        end else begin
          e = sbq.pop_front();
          chk("commit_hi", HI, e.hi);
          chk("commit_lo", LO, e.lo);
          chk("busy_len", 32'(run), 32'(e.len));
        end
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; Req = 1'b0; Start = 1'b0; isMDU_ID = 1'b0;
    MDUOp = 4'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; MDUOp = 4'd5; isMDU_ID = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_stall", 32'(Stall_MDU), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_out", Out, 32'd0);
    step();
    MDUOp = 4'd0; isMDU_ID = 1'b0;

    runOp(4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 6, 1'b0, 1'b0);
    runOp(4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 6, 1'b0, 1'b0);
    runOp(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 11, 1'b1, 1'b0);
    runOp(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 11, 1'b0, 1'b0);

    MDUOp = 4'd7; A = 32'h12345678;
    step();
    MDUOp = 4'd8; A = 32'h9ABCDEF0;
    step();
    MDUOp = 4'd5;
    @(negedge clk);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    chk("mfhi_out", Out, 32'h12345678);
    step();

    runOp(4'd4, 32'h00000064, 32'd0, 32'h12345678, 32'h9ABCDEF0, 11, 1'b0, 1'b0);
    MDUOp = 4'd5;
    @(negedge clk);
    chk("mfhi_after_div0", Out, 32'h12345678);
    step();
    MDUOp = 4'd6;
    @(negedge clk);
    chk("mflo_after_div0", Out, 32'h9ABCDEF0);
    step();

    Start = 1'b1; MDUOp = 4'd1; A = 32'd5; B = 32'd5; Req = 1'b1;
    @(negedge clk);
    chk("req_start_busy", 32'(Busy), 32'd0);
    step();
    Start = 1'b0; MDUOp = 4'd7; A = 32'hDEADBEEF;
    @(negedge clk);
    chk("req_idle_busy", 32'(Busy), 32'd0);
    step();
    Req = 1'b0; MDUOp = 4'd0;
    @(negedge clk);
    chk("req_mthi_hi", HI, 32'h12345678);
    chk("req_mult_lo", LO, 32'h9ABCDEF0);
    step();

    runOp(4'd2, 32'd7, 32'd6, 32'h00000000, 32'h0000002A, 6, 1'b0, 1'b1);

    pushExp(32'h0, 32'h0, 4);
    Start = 1'b1; MDUOp = 4'd1; A = 32'd3; B = 32'd4;
    step();
    Start = 1'b0; MDUOp = 4'd0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (10) step();
    @(negedge clk);
    chk("abort_no_commit_hi", HI, 32'd0);
    chk("abort_no_commit_lo", LO, 32'd0);
    chk("abort_idle", 32'(Busy), 32'd0);

    repeat (3) step();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit with its sequencing controller for the 5-stage MIPS pipeline (P7 CPU).
- Sits in EX: accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from the EX stage, models multi-cycle latency with a busy counter, owns HI/LO.
- Generates the ID-stage stall for any MDU instruction that would collide with a busy unit.
- Honours the CP0 exception/interrupt request, so a flushed EX instruction never alters HI/LO.

Parameters:
MULT_CYC, 5, cycles counted after the Start cycle for mult/multu
DIV_CYC, 10, cycles counted after the Start cycle for div/divu

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
Req  input  1  exception/interrupt flush request from CP0; EX instruction is cancelled this cycle
Start  input  1  EX instruction is mult/multu/div/divu; valid with MDUOp
MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
A  input  32  rs operand (forwarded EX value)
B  input  32  rt operand (forwarded EX value)
isMDU_ID  input  1  instruction in ID is any of MDUOp 1..8
Busy  output  1  unit occupied
Stall_MDU  output  1  stall request to ID/IF: isMDU_ID && Busy
HI  output  32  HI register
LO  output  32  LO register
Out  output  32  mfhi -> HI, mflo -> LO, else 0; combinational from registers

Behaviour:
- Reset: HI=0, LO=0, cnt=0, state IDLE, pending result regs=0; Busy=0, Stall_MDU=0, Out=0. Reset mid-operation aborts; no HI/LO commit.
- States: IDLE, BUSY. cnt is a 4-bit down counter; widen it if the parameters exceed 15.
- IDLE, Start=1, Req=0, MDUOp in 1..4:
  - Compute the result from A/B and latch it in pending regs.
  - Load cnt with MULT_CYC or DIV_CYC, go to BUSY.
- BUSY: cnt decrements each cycle. On the edge where cnt goes 1->0, commit pending to HI/LO, return to IDLE.
- Busy = (Start && !Req && MDUOp in 1..4) || state==BUSY.
  - Timing for mult started in cycle t: Busy high in cycles t..t+5; new HI/LO visible in cycle t+6.
  - For div the window is t..t+10; new HI/LO visible in cycle t+11.
- Arithmetic:
  - mult: signed 64-bit product {HI,LO}=$signed(A)*$signed(B).
  - multu: unsigned 64-bit product.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
- Boundary cases:
  - B==0 on div/divu: busy sequence runs normally; HI/LO unchanged at commit.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo (Req=0): HI or LO <= A at the next edge, only when in IDLE.
- mfhi/mflo: Out reads current HI/LO. The ID stall guarantees these never execute while busy.
- Start while BUSY is illegal: it is prevented by Stall_MDU and ignored if it occurs. MDUOp 7/8 while BUSY is likewise ignored.
- Req=1: Start and mthi/mtlo in that cycle are ignored (flushed). An operation already in BUSY continues and commits, since it has passed EX.
- Start and Req both 1: no state change, Busy follows only the existing state.
- MDUOp 9..15: treated as none.
- Stall_MDU is purely combinational and has no reset dependency beyond Busy.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3 in cycle t -> Busy=1 in t..t+5; in t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- multu A=0xFFFFFFFF, B=2 -> after 6 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> after 11 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; isMDU_ID=1 during t..t+10 -> Stall_MDU=1; isMDU_ID=1 in t+11 -> Stall_MDU=0.
- divu B=0 after mthi 0x12345678 and mtlo 0x9ABCDEF0 -> Busy for 11 cycles, then HI/LO unchanged; mfhi -> Out=0x12345678.
- Start=1, MDUOp=1 with Req=1 -> Busy=0, HI/LO unchanged. mthi A=0xDEADBEEF with Req=1 -> HI unchanged.
- reset asserted at cnt=3 of a mult -> next cycle Busy=0, HI=LO=0, no later commit.
